// File: rtl/vram_rect_fill_if.sv
// Command and VRAM write-port bundle for the rectangle fill engine.
// slave = fill engine, master = command source plus VRAM arbiter.
interface vram_rect_fill_if #(
  parameter int ADDR_W = 17
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_x0;
  logic [7:0]        cmd_y0;
  logic [8:0]        cmd_w;
  logic [7:0]        cmd_h;
  logic [7:0]        cmd_color;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_waddr;
  logic [7:0]        vram_wdata;
  logic              vram_wgnt;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, BASE_ADDR, vram_wgnt,
    output cmd_ready, vram_we, vram_waddr, vram_wdata, busy, done
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, BASE_ADDR, vram_wgnt,
    input  cmd_ready, vram_we, vram_waddr, vram_wdata, busy, done
  );
endinterface

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: clips a command to the 256x192 framebuffer and writes
// one RGB332 pixel per granted cycle in raster order, same addressing as scanout.
module vram_rect_fill #(
  parameter int H_SRC  = 256,
  parameter int V_SRC  = 192,
  parameter int ADDR_W = 17
) (
  input  logic           clk25,
  input  logic           rst,
  vram_rect_fill_if.slave bus
);
  localparam int         XW    = $clog2(H_SRC);
  localparam logic [9:0] H_LIM = 10'(H_SRC);
  localparam logic [8:0] V_LIM = 9'(V_SRC);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state_q;
  logic [7:0]        x_q, y_q, x0_q;
  logic [8:0]        x_end_q;
  logic [7:0]        y_end_q;
  logic [ADDR_W-1:0] base_q;
  logic              ready_q, busy_q, done_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;

  logic [9:0]        x_sum;
  logic [8:0]        y_sum;
  logic [8:0]        x_end_d;
  logic [7:0]        y_end_d;
  logic              empty_d, accept, last_col, last_row;
  logic [7:0]        x_d, y_d;
  logic [ADDR_W-1:0] addr_d, addr0_d;

  always_comb begin
    x_sum    = {2'b00, bus.cmd_x0} + {1'b0, bus.cmd_w};
    y_sum    = {1'b0, bus.cmd_y0} + {1'b0, bus.cmd_h};
    x_end_d  = (x_sum > H_LIM) ? H_LIM[8:0] : x_sum[8:0];
    y_end_d  = (y_sum > V_LIM) ? V_LIM[7:0] : y_sum[7:0];
    // x0 is always on-screen, so only w, h and y0 can make the clip window empty
    empty_d  = (bus.cmd_w == 9'd0) || (bus.cmd_h == 8'd0) || ({1'b0, bus.cmd_y0} >= V_LIM);
    accept   = (state_q == IDLE) && ready_q && bus.cmd_valid;
    last_col = ({1'b0, x_q} == x_end_q - 9'd1);
    last_row = (y_q == y_end_q - 8'd1);
    x_d      = last_col ? x0_q : x_q + 8'd1;
    y_d      = last_col ? y_q + 8'd1 : y_q;
    addr_d   = base_q + (ADDR_W'(y_d) << XW) + ADDR_W'(x_d);
    addr0_d  = bus.BASE_ADDR + (ADDR_W'(bus.cmd_y0) << XW) + ADDR_W'(bus.cmd_x0);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      base_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          if (accept) begin
            ready_q <= 1'b0;
            x0_q    <= bus.cmd_x0;
            x_q     <= bus.cmd_x0;
            y_q     <= bus.cmd_y0;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            base_q  <= bus.BASE_ADDR;
            if (empty_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FILL;
              busy_q  <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= addr0_d;
              wdata_q <= bus.cmd_color;
            end
          end
        end
        FILL: begin
          // without a grant every output holds, so the beat is simply re-presented
          if (bus.vram_wgnt) begin
            if (last_col && last_row) begin
              state_q <= DONE;
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q    <= x_d;
              y_q    <= y_d;
              addr_q <= addr_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_waddr = addr_q;
  assign bus.vram_wdata = wdata_q;
endmodule
